shift_reg_controller: RTL and testbench

- Sequences a parallel-load / bidirectional shift register as a parallel-to-serial transmitter.
- Accepts a word over a valid/ready handshake and loads it (mode 11).
- Shifts it out right (LSB first) or left (MSB first) for a programmable number of bits, filling vacated positions with a fill bit (modes 01/10).
- Holds (mode 00) under output backpressure. Sits between a word producer and a serial sink.

---
 rtl/usr_pkg.sv | 27 ++
 rtl/shift_reg_controller_core.sv | 40 ++++
 rtl/shift_reg_controller.sv | 102 ++++++++++
 tb/tb_shift_reg_controller.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// ----------------------------------------------------------------------------
// usr_pkg : mode encodings, controller states and count helper
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package usr_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // A request of 0, or anything beyond the register width, means "whole word".
  function automatic int unsigned eff_count(input int unsigned cnt, input int unsigned width);
    return ((cnt == 0) || (cnt > width)) ? width : cnt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/shift_reg_controller_core.sv
// ----------------------------------------------------------------------------
// usr_core : WIDTH-bit universal shift register (hold / right / left / load)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module usr_core
  import usr_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [1:0]       s,
  input  logic [WIDTH-1:0] d,
  input  logic             sl,
  input  logic             sr,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q_q <= '0;
    end else begin
      case (s)
        MODE_HOLD: q_q <= q_q;
        MODE_SHR:  q_q <= {sr, q_q[WIDTH-1:1]};
        MODE_SHL:  q_q <= {q_q[WIDTH-2:0], sl};
        MODE_LOAD: q_q <= d;
      endcase
    end
  end

  assign q = q_q;

endmodule

`default_nettype wire

// File: rtl/shift_reg_controller.sv
// ----------------------------------------------------------------------------
// shift_reg_controller : parallel-to-serial transmitter sequencing usr_core
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module shift_reg_controller
  import usr_pkg::*;
#(
  parameter int  WIDTH = 4,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dir,
  input  logic [CW-1:0]    in_count,
  input  logic             in_fill,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             out_ready,
  output logic             done,
  output logic             busy,
  output logic [1:0]       mode,
  output logic [WIDTH-1:0] q
);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          dir_q;
  logic          fill_q;
  logic          accept;
  logic          xfer;
  logic [1:0]    mode_d;

  // Ready is gated by clr so nothing can be accepted while reset is held.
  assign in_ready  = (state_q == ST_IDLE) && !clr;
  assign ser_valid = (state_q == ST_SHIFT);
  assign done      = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign accept    = in_valid && in_ready;
  assign xfer      = ser_valid && out_ready;
  assign ser_out   = dir_q ? q[WIDTH-1] : q[0];

  always_comb begin
    mode_d = MODE_HOLD;
    if (accept) begin
      mode_d = MODE_LOAD;
    end else if (xfer) begin
      mode_d = dir_q ? MODE_SHL : MODE_SHR;
    end
  end

  assign mode = mode_d;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      fill_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            cnt_q   <= CW'(eff_count(32'(in_count), WIDTH));
            dir_q   <= in_dir;
            fill_q  <= in_fill;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (xfer) begin
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
              state_q <= ST_DONE;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  usr_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk (clk),
    .clr (clr),
    .s   (mode_d),
    .d   (in_data),
    .sl  (fill_q),
    .sr  (fill_q),
    .q   (q)
  );

endmodule

`default_nettype wire

// File: tb/tb_shift_reg_controller.sv
// ----------------------------------------------------------------------------
// tb_shift_reg_controller : directed and randomized checks against a word model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_shift_reg_controller;

  logic       clk = 1'b0;
  logic       clr;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       in_dir;
  logic [2:0] in_count;
  logic       in_fill;
  logic       ser_out;
  logic       ser_valid;
  logic       out_ready;
  logic       done;
  logic       busy;
  logic [1:0] mode;
  logic [3:0] q;

  int checks = 0;
  int errors = 0;

  shift_reg_controller #(
    .WIDTH (4)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dir    (in_dir),
    .in_count  (in_count),
    .in_fill   (in_fill),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .out_ready (out_ready),
    .done      (done),
    .busy      (busy),
    .mode      (mode),
    .q         (q)
  );

  always #5 clk = ~clk;

  // Register contents after k bits have left: the word moved by k places with fill entering.
  function automatic int model_q(input int w, input int dir, input int fill, input int k);
    if (dir == 0) return (w >> k) | ((fill != 0) ? (((1 << k) - 1) << (4 - k)) : 0);
    return ((w << k) & 15) | ((fill != 0) ? ((1 << k) - 1) : 0);
  endfunction

  function automatic int model_bit(input int w, input int dir, input int k);
    return (dir == 0) ? ((w >> k) & 1) : ((w >> (3 - k)) & 1);
  endfunction

  task automatic xfer_word(input int w, input int dir, input int cnt, input int fill,
                           input int stall_bit, input int stall_len,
                           input bit rand_stall, input bit junk);
    int n, idx, cyc, fs, ts, guard;
    logic [1:0] exp_mode;
    n = ((cnt == 0) || (cnt > 4)) ? 4 : cnt;
    in_valid  = 1'b1;
    in_data   = 4'(w);
    in_dir    = 1'(dir);
    in_count  = 3'(cnt);
    in_fill   = 1'(fill);
    out_ready = 1'b1;
    #2;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 20) begin
      @(posedge clk); #3;
      guard++;
    end
    checks++;
    if (in_ready !== 1'b1 || mode !== 2'b11 || busy !== 1'b0) begin
      errors++;
      $display("FAIL accept: in_ready=%b mode=%b busy=%b, required 1/11/0", in_ready, mode, busy);
    end
    @(posedge clk); #1;
    in_valid = junk;
    in_data  = junk ? 4'hF : 4'($urandom);
    in_dir   = 1'($urandom);
    in_count = 3'($urandom);
    in_fill  = 1'($urandom);
    idx = 0; cyc = 0; fs = 0; ts = 0;
    while (idx < n && cyc < 100) begin
      if (idx == stall_bit && fs < stall_len) begin
        out_ready = 1'b0; fs++; ts++;
      end else if (rand_stall && $urandom_range(3) == 0) begin
        out_ready = 1'b0; ts++;
      end else begin
        out_ready = 1'b1;
      end
      exp_mode = out_ready ? ((dir != 0) ? 2'b10 : 2'b01) : 2'b00;
      #2;
      checks++;
      if (ser_valid !== 1'b1 || ser_out !== 1'(model_bit(w, dir, idx)) ||
          q !== 4'(model_q(w, dir, fill, idx)) || mode !== exp_mode ||
          in_ready !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL shift bit%0d: valid=%b ser=%b q=%b mode=%b rdy=%b done=%b, required 1/%0d/%b/%b/0/0",
                 idx, ser_valid, ser_out, q, mode, in_ready, done,
                 model_bit(w, dir, idx), 4'(model_q(w, dir, fill, idx)), exp_mode);
      end
      if (out_ready) idx++;
      cyc++;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'($urandom);
    #2;
    checks++;
    if (done !== 1'b1 || ser_valid !== 1'b0 || in_ready !== 1'b0 || mode !== 2'b00 ||
        q !== 4'(model_q(w, dir, fill, n)) || cyc != n + ts) begin
      errors++;
      $display("FAIL done: done=%b valid=%b rdy=%b mode=%b q=%b cycles=%0d, required 1/0/0/00/%b/%0d",
               done, ser_valid, in_ready, mode, q, cyc, 4'(model_q(w, dir, fill, n)), n + ts);
    end
    @(posedge clk); #1;
    #2;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || mode !== 2'b00) begin
      errors++;
      $display("FAIL idle_after_done: done=%b busy=%b rdy=%b mode=%b, required 0/0/1/00",
               done, busy, in_ready, mode);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    clr = 1'b1; in_valid = 1'b1; in_data = 4'hA; in_dir = 1'b0;
    in_count = 3'd4; in_fill = 1'b1; out_ready = 1'b1;
    @(posedge clk); @(posedge clk); #3;
    checks++;
    if (q !== 4'b0000 || in_ready !== 1'b0 || ser_valid !== 1'b0 || done !== 1'b0 ||
        busy !== 1'b0 || mode !== 2'b00) begin
      errors++;
      $display("FAIL reset_held: q=%b rdy=%b valid=%b done=%b busy=%b mode=%b, required 0000/0/0/0/0/00",
               q, in_ready, ser_valid, done, busy, mode);
    end
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    #2;
    checks++;
    if (in_ready !== 1'b1 || mode !== 2'b00 || busy !== 1'b0 || q !== 4'b0000) begin
      errors++;
      $display("FAIL reset_release: rdy=%b mode=%b busy=%b q=%b, required 1/00/0/0000",
               in_ready, mode, busy, q);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_plan_words();
    xfer_word(4'b0100, 0, 4, 0, -1, 0, 1'b0, 1'b0);
    xfer_word(4'b1001, 1, 0, 1, -1, 0, 1'b0, 1'b0);
    xfer_word(4'b1101, 0, 2, 0, -1, 0, 1'b0, 1'b0);
    xfer_word(4'b1010, 1, 7, 0, -1, 0, 1'b0, 1'b0);
    xfer_word(4'b0011, 1, 1, 1, -1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_stall();
    xfer_word(4'b0110, 0, 4, 0, 1, 2, 1'b0, 1'b0);
    xfer_word(4'b1100, 1, 3, 1, 0, 3, 1'b0, 1'b0);
  endtask

  task automatic test_busy_ignore();
    xfer_word(4'b0101, 1, 3, 0, -1, 0, 1'b0, 1'b1);
    xfer_word(4'b0010, 0, 4, 1, 2, 1, 1'b0, 1'b1);
  endtask

  task automatic test_clr_abort();
    in_valid = 1'b1; in_data = 4'b1011; in_dir = 1'b0; in_count = 3'd4;
    in_fill = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2;
    checks++;
    if (busy !== 1'b1 || q !== 4'b0010) begin
      errors++;
      $display("FAIL pre_abort: busy=%b q=%b, required 1/0010", busy, q);
    end
    clr = 1'b1;
    #1;
    checks++;
    if (q !== 4'b0000 || busy !== 1'b0 || ser_valid !== 1'b0 || in_ready !== 1'b0 ||
        mode !== 2'b00 || done !== 1'b0) begin
      errors++;
      $display("FAIL async_clr: q=%b busy=%b valid=%b rdy=%b mode=%b done=%b, required 0000/0/0/0/00/0",
               q, busy, ser_valid, in_ready, mode, done);
    end
    @(posedge clk); #1;
    clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #2;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL post_abort cyc%0d: done=%b busy=%b rdy=%b, required 0/0/1", i, done, busy, in_ready);
      end
      @(posedge clk); #1;
    end
    xfer_word(4'b1110, 0, 3, 1, -1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      xfer_word(int'($urandom_range(15)), int'($urandom_range(1)), int'($urandom_range(7)),
                int'($urandom_range(1)), -1, 0, 1'b1, 1'($urandom));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_plan_words();
    test_stall();
    test_busy_ignore();
    test_clr_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
